sensor_poll_ctrl: RTL and testbench

Sequencer for the sensor bus: accepts a sensor-poll command, drives the UART transmitter with the sensor number, waits for the 2-byte reply (data byte + CRC byte) from the UART receiver, qualifies it with the external checksum block, and retries on CRC failure or timeout. It sits between the user-facing state selection logic and the uart_tx / uart_rx / checksum instances, and is the only block driving their control inputs.

---
 rtl/sensor_poll_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sensor_poll_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_poll_ctrl.sv
// Sensor bus poll sequencer: sends a sensor id over uart_tx, collects the 2-byte
// reply from uart_rx, qualifies it with the checksum block and retries on CRC failure or timeout.
module sensor_poll_ctrl #(
    parameter int NUM_SENSORS    = 6,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 2,
    parameter int CNT_W          = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_sensor,
    output logic        cmd_ready,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic        tx_done,
    input  logic [15:0] rx_data,
    input  logic        rx_done,
    output logic [15:0] chk_word,
    input  logic        crc_ok,
    output logic        result_valid,
    output logic [7:0]  result_data,
    output logic [2:0]  result_sensor,
    output logic [1:0]  result_err,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and nothing is queued while busy.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_WAIT_TX = 3'd2,
        S_WAIT_RX = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [1:0]       ERR_OK      = 2'b00;
    localparam logic [1:0]       ERR_CRC     = 2'b01;
    localparam logic [1:0]       ERR_TIMEOUT = 2'b10;
    localparam logic [1:0]       ERR_BAD_ID  = 2'b11;
    localparam logic [2:0]       ID_MAX      = 3'(NUM_SENSORS);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);
    localparam logic [CNT_W-1:0] TIMER_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [2:0]       sensor_id;
    logic [3:0]       retry_cnt;
    logic [CNT_W-1:0] timer;
    logic             id_ok;
    logic             expired;
    logic             retry_left;
    logic             fail;
    logic [1:0]       fail_code;

    assign id_ok      = (cmd_sensor != 3'd0) && (cmd_sensor <= ID_MAX);
    assign expired    = (timer == TIMER_LAST);
    assign retry_left = (retry_cnt < RETRY_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Completion pulses take priority over timer expiry in the same cycle.
    always_comb begin
        next_state = state;
        fail       = 1'b0;
        fail_code  = ERR_OK;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    next_state = id_ok ? S_SEND : S_DONE;
                end
            end
            S_SEND: next_state = S_WAIT_TX;
            S_WAIT_TX: begin
                if (tx_done) begin
                    next_state = S_WAIT_RX;
                end else if (expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            S_WAIT_RX: begin
                if (rx_done) begin
                    next_state = S_CHECK;
                end else if (expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            S_CHECK: begin
                if (crc_ok) begin
                    next_state = S_DONE;
                end else begin
                    fail      = 1'b1;
                    fail_code = ERR_CRC;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (fail) begin
            next_state = retry_left ? S_SEND : S_DONE;
        end
    end

    always_comb begin
        cmd_ready    = (state == S_IDLE);
        busy         = (state != S_IDLE);
        tx_enable    = (state == S_SEND);
        result_valid = (state == S_DONE);
        tx_data      = {5'd0, sensor_id};
        state_dbg    = state;
    end

    // Result registers are loaded on the edge into DONE and then hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sensor_id     <= 3'd0;
            retry_cnt     <= 4'd0;
            timer         <= '0;
            chk_word      <= 16'd0;
            result_data   <= 8'd0;
            result_sensor <= 3'd0;
            result_err    <= ERR_OK;
        end else begin
            if (state != next_state) begin
                timer <= '0;
            end else if (state == S_WAIT_TX || state == S_WAIT_RX) begin
                timer <= timer + 1'b1;
            end

            if (state == S_IDLE && cmd_valid) begin
                sensor_id <= cmd_sensor;
                retry_cnt <= 4'd0;
                if (!id_ok) begin
                    result_err    <= ERR_BAD_ID;
                    result_data   <= 8'd0;
                    result_sensor <= cmd_sensor;
                end
            end

            if (state == S_WAIT_RX && rx_done) begin
                chk_word <= rx_data;
            end

            if (state == S_CHECK && crc_ok) begin
                result_err    <= ERR_OK;
                result_data   <= chk_word[7:0];
                result_sensor <= sensor_id;
            end

            if (fail) begin
                if (retry_left) begin
                    retry_cnt <= retry_cnt + 4'd1;
                end else begin
                    result_err    <= fail_code;
                    result_data   <= 8'd0;
                    result_sensor <= sensor_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_poll_ctrl.sv
// Directed bench for sensor_poll_ctrl with a short timeout so retry/timeout
// sequences complete quickly; every expected value is hand-derived.
module tb_sensor_poll_ctrl;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd_sensor;
    logic        cmd_ready;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_done;
    logic [15:0] rx_data;
    logic        rx_done;
    logic [15:0] chk_word;
    logic        crc_ok;
    logic        result_valid;
    logic [7:0]  result_data;
    logic [2:0]  result_sensor;
    logic [1:0]  result_err;
    logic        busy;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int tx_pulses  = 0;
    int res_pulses = 0;
    int tx_base;
    int res_base;

    sensor_poll_ctrl #(
        .NUM_SENSORS(6),
        .TIMEOUT_CYCLES(20),
        .MAX_RETRY(2),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_sensor(cmd_sensor),
        .cmd_ready(cmd_ready),
        .tx_data(tx_data),
        .tx_enable(tx_enable),
        .tx_done(tx_done),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .chk_word(chk_word),
        .crc_ok(crc_ok),
        .result_valid(result_valid),
        .result_data(result_data),
        .result_sensor(result_sensor),
        .result_err(result_err),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (tx_enable) tx_pulses <= tx_pulses + 1;
        if (result_valid) res_pulses <= res_pulses + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [2:0] id);
        cmd_valid  = 1'b1;
        cmd_sensor = id;
        step();
        cmd_valid  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_tx_enable"}, 32'(tx_enable), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_chk_word"}, 32'(chk_word), 32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_result_data"}, 32'(result_data), 32'd0);
        check({tag, "_result_sensor"}, 32'(result_sensor), 32'd0);
        check({tag, "_result_err"}, 32'(result_err), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_sensor = 3'd0;
        tx_done    = 1'b0;
        rx_data    = 16'd0;
        rx_done    = 1'b0;
        crc_ok     = 1'b0;
        steps(2);
        check_reset_outputs("por");
        reset = 1'b1;
        step();

        // Sensor 3, single clean exchange
        tx_base = tx_pulses;
        res_base = res_pulses;
        accept(3'd3);
        check("s3_tx_enable", 32'(tx_enable), 32'd1);
        check("s3_tx_data", 32'(tx_data), 32'h03);
        check("s3_cmd_ready_low", 32'(cmd_ready), 32'd0);
        check("s3_busy", 32'(busy), 32'd1);
        step();
        check("s3_tx_enable_one_cycle", 32'(tx_enable), 32'd0);
        steps(9);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        steps(3);
        rx_done = 1'b1;
        rx_data = 16'hA55A;
        crc_ok  = 1'b1;
        step();
        rx_done = 1'b0;
        check("s3_check_no_result", 32'(result_valid), 32'd0);
        check("s3_chk_word", 32'(chk_word), 32'hA55A);
        step();
        check("s3_result_valid", 32'(result_valid), 32'd1);
        check("s3_result_data", 32'(result_data), 32'h5A);
        check("s3_result_sensor", 32'(result_sensor), 32'd3);
        check("s3_result_err", 32'(result_err), 32'd0);
        step();
        check("s3_result_pulse_end", 32'(result_valid), 32'd0);
        check("s3_cmd_ready_back", 32'(cmd_ready), 32'd1);
        check("s3_tx_count", 32'(tx_pulses - tx_base), 32'd1);
        check("s3_res_count", 32'(res_pulses - res_base), 32'd1);

        // Bad ids 0 and 7: immediate result, no UART activity
        tx_base = tx_pulses;
        for (int k = 0; k < 2; k++) begin
            logic [2:0] id;
            id = (k == 0) ? 3'd0 : 3'd7;
            accept(id);
            check("badid_result_valid", 32'(result_valid), 32'd1);
            check("badid_result_err", 32'(result_err), 32'd3);
            check("badid_result_data", 32'(result_data), 32'd0);
            check("badid_result_sensor", 32'(result_sensor), 32'(id));
            check("badid_tx_enable", 32'(tx_enable), 32'd0);
            step();
            check("badid_cmd_ready", 32'(cmd_ready), 32'd1);
        end
        check("badid_tx_count", 32'(tx_pulses - tx_base), 32'd0);

        // Sensor 2, two CRC failures then success
        tx_base = tx_pulses;
        res_base = res_pulses;
        accept(3'd2);
        for (int a = 0; a < 3; a++) begin
            step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            rx_done = 1'b1;
            rx_data = {8'hC0, 8'(8'h10 + a)};
            crc_ok  = (a == 2);
            step();
            rx_done = 1'b0;
            step();
            if (a < 2) check("crc_retry_send", 32'(tx_enable), 32'd1);
        end
        check("crc_result_valid", 32'(result_valid), 32'd1);
        check("crc_result_err", 32'(result_err), 32'd0);
        check("crc_result_data", 32'(result_data), 32'h12);
        check("crc_result_sensor", 32'(result_sensor), 32'd2);
        step();
        check("crc_tx_count", 32'(tx_pulses - tx_base), 32'd3);
        check("crc_res_count", 32'(res_pulses - res_base), 32'd1);

        // Sensor 5, reply never arrives: three full timeouts
        tx_base = tx_pulses;
        res_base = res_pulses;
        crc_ok = 1'b0;
        accept(3'd5);
        for (int a = 0; a < 3; a++) begin
            step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            steps(19);
            check("to_still_wait_rx", 32'(state_dbg), 32'd3);
            check("to_no_early_result", 32'(result_valid), 32'd0);
            step();
            if (a < 2) check("to_retry_send", 32'(tx_enable), 32'd1);
        end
        check("to_result_valid", 32'(result_valid), 32'd1);
        check("to_result_err", 32'(result_err), 32'd2);
        check("to_result_sensor", 32'(result_sensor), 32'd5);
        step();
        check("to_tx_count", 32'(tx_pulses - tx_base), 32'd3);
        check("to_res_count", 32'(res_pulses - res_base), 32'd1);

        // rx_done on the expiry cycle is accepted without retry
        tx_base = tx_pulses;
        accept(3'd4);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        steps(19);
        check("coin_wait_rx", 32'(state_dbg), 32'd3);
        rx_done = 1'b1;
        rx_data = 16'h3C77;
        crc_ok  = 1'b1;
        step();
        rx_done = 1'b0;
        check("coin_in_check", 32'(state_dbg), 32'd4);
        check("coin_no_retry", 32'(tx_enable), 32'd0);
        step();
        check("coin_result_valid", 32'(result_valid), 32'd1);
        check("coin_result_err", 32'(result_err), 32'd0);
        check("coin_result_data", 32'(result_data), 32'h77);
        step();
        check("coin_tx_count", 32'(tx_pulses - tx_base), 32'd1);

        // Reset while waiting for the reply, then a stray rx_done
        res_base = res_pulses;
        crc_ok = 1'b1;
        accept(3'd1);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        steps(2);
        check("rst_in_wait_rx", 32'(state_dbg), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        step();
        reset = 1'b1;
        rx_done = 1'b1;
        rx_data = 16'hBEEF;
        step();
        rx_done = 1'b0;
        steps(3);
        check_reset_outputs("rst_stray");
        check("rst_no_result", 32'(res_pulses - res_base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
